// File: rtl/fir_pkg.sv
// Shared FIR datapath definitions: widths, tap count and signed data typedefs.
// Latency: n/a (package).
// Backpressure: n/a (package).
//
// The control unit sizes its tap address from TAPS here, so the MAC window
// length and the address range can never drift apart.
package fir_pkg;

    localparam int DATA_W = 8;                                 // sample width
    localparam int COEF_W = 8;                                 // coefficient width
    localparam int TAPS   = 8;                                 // products per output
    localparam int ACC_W  = DATA_W + COEF_W + $clog2(TAPS);    // overflow-free sum
    localparam int SHIFT  = 7;                                 // coefficient fraction bits
    localparam int OUT_W  = 8;                                 // output width

    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ADDR_W = $clog2(TAPS);                      // control unit address width
    localparam int CNT_W  = $clog2(TAPS + 1);                  // must be able to hold TAPS

    typedef logic signed [DATA_W-1:0] sample_t;
    typedef logic signed [COEF_W-1:0] coef_t;
    typedef logic signed [PROD_W-1:0] prod_t;
    typedef logic signed [ACC_W-1:0]  acc_t;
    typedef logic signed [OUT_W-1:0]  out_t;

endpackage

// File: rtl/fir_round_sat.sv
// Round-half-up arithmetic right shift followed by saturation to OUT_W bits.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; output follows the input every cycle.
//
// Ports:
//   sum_in  in   ACC_W  signed accumulator value
//   res_out out  OUT_W  signed rounded and saturated result
module fir_round_sat #(
    parameter int ACC_W = fir_pkg::ACC_W,
    parameter int SHIFT = fir_pkg::SHIFT,
    parameter int OUT_W = fir_pkg::OUT_W
) (
    input  logic signed [ACC_W-1:0] sum_in,
    output logic signed [OUT_W-1:0] res_out
);

    // One guard bit so adding the rounding constant can never wrap.
    localparam int EXT_W = ACC_W + 1;

    // Half an LSB of the shifted result; evaluates to zero when SHIFT == 0,
    // which turns rounding off without a separate code path.
    localparam logic signed [EXT_W-1:0] HALF  = EXT_W'((1 << SHIFT) >> 1);
    localparam logic signed [EXT_W-1:0] MAX_E = EXT_W'((1 << (OUT_W - 1)) - 1);
    // Bitwise inverse of 0..0111 is 1..1000, the most negative OUT_W value.
    localparam logic signed [EXT_W-1:0] MIN_E = ~MAX_E;

    logic signed [EXT_W-1:0] sum_ext;
    logic signed [EXT_W-1:0] biased;
    logic signed [EXT_W-1:0] shifted;

    always_comb begin
        sum_ext = EXT_W'(sum_in);
        biased  = sum_ext + HALF;
        // Arithmetic shift floors, so floor(x + 0.5) gives round half toward +inf.
        shifted = biased >>> SHIFT;

        if (shifted > MAX_E) begin
            res_out = OUT_W'(MAX_E);
        end else if (shifted < MIN_E) begin
            res_out = OUT_W'(MIN_E);
        end else begin
            res_out = OUT_W'(shifted);
        end
    end

endmodule

// File: rtl/fir_mac.sv
// FIR multiply-accumulate stage: sums TAPS signed products per window, then rounds/saturates.
// Latency: tap-0 strobe in cycle C0, back-to-back taps -> y/valid_out in cycle C0+TAPS+2.
// Backpressure: none; accepts one tap per cycle, en gaps simply stall the window in place.
//
// Ports:
//   clock      in   1       system clock, rising edge
//   reset      in   1       asynchronous active-high reset
//   en         in   1       tap strobe; the memory read for this tap is issued this cycle
//   mac_init   in   1       with en: this tap opens a new window (aborts any open one)
//   coeff      in   COEF_W  ROM data, valid the cycle after the en that addressed it
//   sample     in   DATA_W  RAM data, valid the cycle after the en that addressed it
//   y          out  OUT_W   filtered sample, held between updates
//   valid_out  out  1       one-cycle pulse when y updates
//   busy       out  1       high from first accepted tap through the valid_out cycle
module fir_mac #(
    parameter int DATA_W = fir_pkg::DATA_W,
    parameter int COEF_W = fir_pkg::COEF_W,
    parameter int TAPS   = fir_pkg::TAPS,
    parameter int ACC_W  = DATA_W + COEF_W + $clog2(TAPS),
    parameter int SHIFT  = fir_pkg::SHIFT,
    parameter int OUT_W  = fir_pkg::OUT_W
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     mac_init,
    input  logic signed [COEF_W-1:0] coeff,
    input  logic signed [DATA_W-1:0] sample,
    output logic signed [OUT_W-1:0]  y,
    output logic                     valid_out,
    output logic                     busy
);

    localparam int PROD_W = DATA_W + COEF_W;
    localparam int CNT_W  = $clog2(TAPS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TAPS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    // Stage 0: strobes delayed to line up with synchronous memory data.
    logic en_d1_q,   en_d1_d;
    logic init_d1_q, init_d1_d;
    // Stage 1: product register plus strobes.
    logic en_d2_q,   en_d2_d;
    logic init_d2_q, init_d2_d;
    logic signed [PROD_W-1:0] prod_q, prod_d;
    // Stage 2: accumulator and window tracking.
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]         tap_cnt_q, tap_cnt_d;
    logic                     active_q, active_d;
    // Output registers.
    logic signed [OUT_W-1:0]  y_q, y_d;
    logic                     valid_q, valid_d;
    logic                     busy_q, busy_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  acc_next;
    logic [CNT_W-1:0]         cnt_next;
    logic                     take;
    logic                     done;
    logic signed [OUT_W-1:0]  y_rnd;

    // The rounder sees the sum including the product being accumulated this
    // cycle, so y registers on the same edge as the final accumulation.
    fir_round_sat #(
        .ACC_W (ACC_W),
        .SHIFT (SHIFT),
        .OUT_W (OUT_W)
    ) u_round_sat (
        .sum_in  (acc_next),
        .res_out (y_rnd)
    );

    always_comb begin
        // Stage 0
        en_d1_d   = en;
        init_d1_d = en & mac_init;

        // Stage 1: product only loads on a real tap so bubbles leave it alone.
        en_d2_d   = en_d1_q;
        init_d2_d = init_d1_q;
        prod_d    = en_d1_q ? PROD_W'(sample * coeff) : prod_q;

        // Stage 2
        prod_ext = ACC_W'(prod_q);
        // A new window restarts from the bare product; otherwise keep summing.
        acc_next = init_d2_q ? prod_ext : (acc_q + prod_ext);
        cnt_next = init_d2_q ? CNT_ONE : (tap_cnt_q + CNT_ONE);

        // Strobes arriving with no open window (and no init) are dropped.
        take = en_d2_q & (init_d2_q | active_q);
        done = take & (cnt_next == CNT_LAST);

        acc_d     = acc_q;
        tap_cnt_d = tap_cnt_q;
        active_d  = active_q;
        y_d       = y_q;
        valid_d   = 1'b0;

        if (take) begin
            acc_d     = acc_next;
            tap_cnt_d = cnt_next;
            active_d  = 1'b1;
        end

        if (done) begin
            // Window closes here; the next init may arrive on the very next
            // cycle and is accepted without a stall.
            tap_cnt_d = '0;
            active_d  = 1'b0;
            y_d       = y_rnd;
            valid_d   = 1'b1;
        end

        // busy covers the open window plus the cycle valid_out is shown.
        busy_d = active_d | valid_d;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            en_d1_q   <= 1'b0;
            init_d1_q <= 1'b0;
            en_d2_q   <= 1'b0;
            init_d2_q <= 1'b0;
            prod_q    <= '0;
            acc_q     <= '0;
            tap_cnt_q <= '0;
            active_q  <= 1'b0;
            y_q       <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            en_d1_q   <= en_d1_d;
            init_d1_q <= init_d1_d;
            en_d2_q   <= en_d2_d;
            init_d2_q <= init_d2_d;
            prod_q    <= prod_d;
            acc_q     <= acc_d;
            tap_cnt_q <= tap_cnt_d;
            active_q  <= active_d;
            y_q       <= y_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
        end
    end

    assign y         = y_q;
    assign valid_out = valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_fir_mac.sv
// Testbench for fir_mac: emulates ROM/RAM read latency and compares output pulses
// against a window-level reference model (sum of products, floor-divide rounding, clamp).
module tb_fir_mac;
    import fir_pkg::*;

    logic    clock = 1'b0;
    logic    reset;
    logic    en;
    logic    mac_init;
    coef_t   coeff;
    sample_t sample;
    out_t    y;
    logic    valid_out;
    logic    busy;

    fir_mac dut (
        .clock     (clock),
        .reset     (reset),
        .en        (en),
        .mac_init  (mac_init),
        .coeff     (coeff),
        .sample    (sample),
        .y         (y),
        .valid_out (valid_out),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int y;
    } pulse_t;

    pulse_t exp_q[$];
    pulse_t act_q[$];

    int checks   = 0;
    int failures = 0;

    // Memory emulation: data for a strobe appears on the following cycle.
    bit pend_vld = 1'b0;
    int pend_c   = 0;
    int pend_s   = 0;

    // Reference model state: one open window at most.
    bit     m_active = 1'b0;
    int     m_cnt    = 0;
    longint m_sum    = 0;

    always @(negedge clock) begin
        if (!reset && valid_out) begin
            act_q.push_back('{cyc, int'(y)});
        end
    end

    // Divide by 2^SHIFT rounding half toward +inf, then clamp to OUT_W.
    function automatic int ref_y(input longint sum);
        longint div;
        longint t;
        longint q;
        longint hi;
        div = longint'(1) << SHIFT;
        t   = sum + div / 2;
        q   = t / div;
        if (t < 0 && (t % div) != 0) q = q - 1;
        hi  = (longint'(1) << (OUT_W - 1)) - 1;
        if (q > hi) q = hi;
        if (q < -hi - 1) q = -hi - 1;
        return int'(q);
    endfunction

    function automatic int rnd8();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    // One clock cycle of stimulus; the strobe cycle number is cyc on return.
    task automatic step(input bit e, input bit i, input int c, input int s);
        @(negedge clock);
        en       = e;
        mac_init = i;
        if (pend_vld) begin
            coeff  = COEF_W'(pend_c);
            sample = DATA_W'(pend_s);
        end else begin
            coeff  = COEF_W'($urandom);
            sample = DATA_W'($urandom);
        end
        if (e) begin
            if (i) begin
                m_active = 1'b1;
                m_cnt    = 1;
                m_sum    = longint'(c) * longint'(s);
            end else if (m_active) begin
                m_cnt = m_cnt + 1;
                m_sum = m_sum + longint'(c) * longint'(s);
            end
            if (m_active && m_cnt == TAPS) begin
                // Last tap in cycle k: result visible in cycle k+3.
                exp_q.push_back('{cyc + 3, ref_y(m_sum)});
                m_active = 1'b0;
            end
        end
        pend_vld = e;
        pend_c   = c;
        pend_s   = s;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 0, 0);
    endtask

    task automatic clear_q();
        exp_q.delete();
        act_q.delete();
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        en       = 1'b0;
        mac_init = 1'b0;
        coeff    = '0;
        sample   = '0;
        repeat (3) @(negedge clock);
        checks++;
        if (y !== '0) begin failures++; $display("FAIL reset_y actual=%0d required=0", y); end
        checks++;
        if (valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid actual=%b required=0", valid_out); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy actual=%b required=0", busy); end
        reset    = 1'b0;
        m_active = 1'b0;
        pend_vld = 1'b0;
    endtask

    task automatic test_all16();
        int c0;
        clear_q();
        c0 = 0;
        for (int t = 0; t < TAPS; t++) begin
            step(1'b1, t == 0, 16, 8);
            if (t == 0) c0 = cyc;
        end
        idle(14);
        checks++;
        if (act_q.size() != 1) begin
            failures++; $display("FAIL all16_count actual=%0d required=1", act_q.size());
        end else begin
            checks++;
            if (act_q[0].cyc - c0 != 10) begin failures++; $display("FAIL all16_latency actual=%0d required=10", act_q[0].cyc - c0); end
            checks++;
            if (act_q[0].y != 8) begin failures++; $display("FAIL all16_y actual=%0d required=8", act_q[0].y); end
        end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL all16_busy_idle actual=%b required=0", busy); end
        checks++;
        if (y !== 8'sd8) begin failures++; $display("FAIL all16_y_hold actual=%0d required=8", y); end
    endtask

    task automatic test_round();
        int req[2];
        clear_q();
        req[0] = 2;
        req[1] = -1;
        for (int w = 0; w < 2; w++) begin
            for (int t = 0; t < TAPS; t++) begin
                if (t == 0) step(1'b1, 1'b1, 3, (w == 0) ? 64 : -64);
                else        step(1'b1, 1'b0, 0, rnd8());
            end
            idle(12);
        end
        checks++;
        if (act_q.size() != 2) begin
            failures++; $display("FAIL round_count actual=%0d required=2", act_q.size());
        end else begin
            for (int w = 0; w < 2; w++) begin
                checks++;
                if (act_q[w].y != req[w]) begin failures++; $display("FAIL round_y%0d actual=%0d required=%0d", w, act_q[w].y, req[w]); end
            end
        end
    endtask

    task automatic test_sat();
        int req[2];
        clear_q();
        req[0] = 127;
        req[1] = -128;
        for (int w = 0; w < 2; w++) begin
            for (int t = 0; t < TAPS; t++) step(1'b1, t == 0, 127, (w == 0) ? 127 : -128);
            idle(12);
        end
        checks++;
        if (act_q.size() != 2) begin
            failures++; $display("FAIL sat_count actual=%0d required=2", act_q.size());
        end else begin
            for (int w = 0; w < 2; w++) begin
                checks++;
                if (act_q[w].y != req[w]) begin failures++; $display("FAIL sat_y%0d actual=%0d required=%0d", w, act_q[w].y, req[w]); end
            end
        end
    endtask

    task automatic test_gap();
        int c[TAPS];
        int s[TAPS];
        int c0[2];
        clear_q();
        for (int t = 0; t < TAPS; t++) begin c[t] = rnd8(); s[t] = rnd8(); end
        for (int w = 0; w < 2; w++) begin
            for (int t = 0; t < TAPS; t++) begin
                step(1'b1, t == 0, c[t], s[t]);
                if (t == 0) c0[w] = cyc;
                if (w == 1 && t == 2) idle(3);
            end
            idle(14);
        end
        checks++;
        if (act_q.size() != exp_q.size()) begin failures++; $display("FAIL gap_count actual=%0d required=%0d", act_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            if (i < act_q.size()) begin
                checks++;
                if (act_q[i].cyc != exp_q[i].cyc || act_q[i].y != exp_q[i].y) begin
                    failures++;
                    $display("FAIL gap_pulse%0d actual=cyc%0d/y%0d required=cyc%0d/y%0d", i, act_q[i].cyc, act_q[i].y, exp_q[i].cyc, exp_q[i].y);
                end
            end
        end
        if (act_q.size() == 2) begin
            checks++;
            if (act_q[1].cyc - c0[1] != 13) begin failures++; $display("FAIL gap_latency actual=%0d required=13", act_q[1].cyc - c0[1]); end
        end
    endtask

    task automatic test_back_to_back();
        clear_q();
        // Two full windows with no gap.
        for (int w = 0; w < 2; w++) begin
            for (int t = 0; t < TAPS; t++) step(1'b1, t == 0, rnd8(), rnd8());
        end
        // Third window aborted at tap 5 by a fresh init, then completed.
        for (int t = 0; t < 5; t++) step(1'b1, t == 0, rnd8(), rnd8());
        for (int t = 0; t < TAPS; t++) step(1'b1, t == 0, rnd8(), rnd8());
        idle(14);
        checks++;
        if (act_q.size() != exp_q.size()) begin failures++; $display("FAIL b2b_count actual=%0d required=%0d", act_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            if (i < act_q.size()) begin
                checks++;
                if (act_q[i].cyc != exp_q[i].cyc || act_q[i].y != exp_q[i].y) begin
                    failures++;
                    $display("FAIL b2b_pulse%0d actual=cyc%0d/y%0d required=cyc%0d/y%0d", i, act_q[i].cyc, act_q[i].y, exp_q[i].cyc, exp_q[i].y);
                end
            end
        end
        if (act_q.size() >= 2) begin
            checks++;
            if (act_q[1].cyc - act_q[0].cyc != TAPS) begin failures++; $display("FAIL b2b_spacing actual=%0d required=%0d", act_q[1].cyc - act_q[0].cyc, TAPS); end
        end
    endtask

    task automatic test_reset_mid();
        clear_q();
        for (int t = 0; t < 5; t++) step(1'b1, t == 0, rnd8(), rnd8());
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL rstmid_busy_before actual=%b required=1", busy); end
        #2;
        reset    = 1'b1;
        m_active = 1'b0;
        #1;
        checks++;
        if (y !== '0) begin failures++; $display("FAIL rstmid_y actual=%0d required=0", y); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy actual=%b required=0", busy); end
        en       = 1'b0;
        mac_init = 1'b0;
        @(negedge clock);
        reset    = 1'b0;
        pend_vld = 1'b0;
        idle(12);
        checks++;
        if (act_q.size() != 0) begin failures++; $display("FAIL rstmid_no_pulse actual=%0d required=0", act_q.size()); end
        for (int t = 0; t < TAPS; t++) step(1'b1, t == 0, rnd8(), rnd8());
        idle(14);
        checks++;
        if (act_q.size() != exp_q.size()) begin failures++; $display("FAIL rstmid_count actual=%0d required=%0d", act_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            if (i < act_q.size()) begin
                checks++;
                if (act_q[i].cyc != exp_q[i].cyc || act_q[i].y != exp_q[i].y) begin
                    failures++;
                    $display("FAIL rstmid_pulse%0d actual=cyc%0d/y%0d required=cyc%0d/y%0d", i, act_q[i].cyc, act_q[i].y, exp_q[i].cyc, exp_q[i].y);
                end
            end
        end
    endtask

    task automatic test_random();
        clear_q();
        for (int n = 0; n < 300; n++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0, rnd8(), rnd8());
        end
        idle(14);
        checks++;
        if (act_q.size() != exp_q.size()) begin failures++; $display("FAIL rand_count actual=%0d required=%0d", act_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            if (i < act_q.size()) begin
                checks++;
                if (act_q[i].cyc != exp_q[i].cyc || act_q[i].y != exp_q[i].y) begin
                    failures++;
                    $display("FAIL rand_pulse%0d actual=cyc%0d/y%0d required=cyc%0d/y%0d", i, act_q[i].cyc, act_q[i].y, exp_q[i].cyc, exp_q[i].y);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_all16();
        test_round();
        test_sat();
        test_gap();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
